// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches MIPS instructions over a req/ack memory port and
// holds each one for the decode stage behind a valid/ready handshake.
// It applies branch redirects from execute to the PC.
// Optional build macro: BRANCH_DELAY_SLOT_EN selects MIPS delay-slot semantics.
// When the macro is undefined, a redirect squashes the in-flight instruction.
`timescale 1ns/1ps
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        br_taken,
   input  logic [31:0] br_target
);

   typedef enum logic {S_REQ, S_VALID} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_out_q, pc_out_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic        redir_q, redir_d;   // a redirect is waiting to be applied
   logic [31:0] tgt_q, tgt_d;       // saved redirect target

   logic [31:0] br_tgt;
   logic [31:0] pc_inc;
   logic        ack_hit;

   assign br_tgt  = br_target & 32'hFFFF_FFFC;
   assign pc_inc  = pc_q + 32'd4;            // wraps modulo 2^32
   assign ack_hit = req_q & imem_ack;        // an ack only counts while a request is out

   // All outputs come directly from registers.
   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr_valid = valid_q;
   assign instr       = instr_q;
   assign op          = instr_q[31:26];
   assign pc_out      = pc_out_q;
   assign pc_plus4    = pc_plus4_q;

   // State register with asynchronous reset; reset abandons any transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         instr_q    <= 32'h0;
         pc_out_q   <= 32'h0;
         pc_plus4_q <= 32'd4;
         valid_q    <= 1'b0;
         req_q      <= 1'b0;
         redir_q    <= 1'b0;
         tgt_q      <= 32'h0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         pc_out_q   <= pc_out_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
         req_q      <= req_d;
         redir_q    <= redir_d;
         tgt_q      <= tgt_d;
      end
   end

   // Next-state logic: fetch handshake, decode handshake, and redirect handling.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      pc_out_d   = pc_out_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      req_d      = req_q;
      redir_d    = redir_q;
      tgt_d      = tgt_q;

      case (state_q)
         S_REQ: begin
            req_d   = 1'b1;
            valid_d = 1'b0;
            if (!req_q) begin
               // Nothing is outstanding yet (first cycle after reset), so a
               // redirect can retarget the very first request directly.
               if (br_taken) pc_d = br_tgt;
            end else if (ack_hit) begin
`ifdef BRANCH_DELAY_SLOT_EN
               // The returned word is the delay slot; deliver it, then
               // continue at the redirect target if one is due.
               instr_d    = imem_rdata;
               pc_out_d   = pc_q;
               pc_plus4_d = pc_inc;
               valid_d    = 1'b1;
               req_d      = 1'b0;
               state_d    = S_VALID;
               redir_d    = 1'b0;
               if (br_taken)     pc_d = br_tgt;
               else if (redir_q) pc_d = tgt_q;
               else              pc_d = pc_inc;
`else
               if (br_taken) begin
                  // Word belongs to the wrong path; drop it and refetch.
                  pc_d    = br_tgt;
                  redir_d = 1'b0;
               end else if (redir_q) begin
                  pc_d    = tgt_q;
                  redir_d = 1'b0;
               end else begin
                  instr_d    = imem_rdata;
                  pc_out_d   = pc_q;
                  pc_plus4_d = pc_inc;
                  pc_d       = pc_inc;
                  valid_d    = 1'b1;
                  req_d      = 1'b0;
                  state_d    = S_VALID;
               end
`endif
            end else if (br_taken) begin
               // Memory request in flight cannot be aborted: remember target.
               redir_d = 1'b1;
               tgt_d   = br_tgt;
            end
         end

         S_VALID: begin
            req_d   = 1'b0;
            valid_d = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
            if (instr_ready) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = S_REQ;
               redir_d = 1'b0;
               if (br_taken)     pc_d = br_tgt;
               else if (redir_q) pc_d = tgt_q;
            end else if (br_taken) begin
               redir_d = 1'b1;
               tgt_d   = br_tgt;
            end
`else
            if (br_taken) begin
               // Squash the held instruction, even if decode takes it now.
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = S_REQ;
               pc_d    = br_tgt;
            end else if (instr_ready) begin
               valid_d = 1'b0;
               req_d   = 1'b1;
               state_d = S_REQ;
            end
`endif
         end

         default: begin
            state_d = S_REQ;
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected
// instructions, pushed when memory returns a word that should be delivered.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        rst_n, imem_req, imem_ack, instr_valid, instr_ready, br_taken;
   logic [31:0] imem_addr, imem_rdata, instr, pc_out, pc_plus4, br_target;
   logic [5:0]  op;

   logic        rst2_n, imem_req2, imem_ack2, instr_valid2, instr_ready2, br_taken2;
   logic [31:0] imem_addr2, imem_rdata2, instr2, pc_out2, pc_plus42, br_target2;
   logic [5:0]  op2;

   int   n_chk  = 0;
   int   n_pass = 0;
   exp_t sb[$];

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .op(op),
      .pc_out(pc_out), .pc_plus4(pc_plus4), .br_taken(br_taken), .br_target(br_target)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .rst_n(rst2_n),
      .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
      .instr_valid(instr_valid2), .instr_ready(instr_ready2), .instr(instr2), .op(op2),
      .pc_out(pc_out2), .pc_plus4(pc_plus42), .br_taken(br_taken2), .br_target(br_target2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Decode takes the held instruction; compare it against the scoreboard head.
   task automatic accept(input string tag);
      exp_t e;
      chk({tag, "_valid"}, {31'h0, instr_valid}, 32'd1);
      if (sb.size() == 0) begin
         n_chk++;
         $error("FAIL %s_sb: got handshake expected a queued instruction", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_instr"}, instr, e.instr);
         chk({tag, "_op"}, {26'h0, op}, {26'h0, e.instr[31:26]});
         chk({tag, "_pc"}, pc_out, e.pc);
         chk({tag, "_pc4"}, pc_plus4, e.pc + 32'd4);
      end
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      chk({tag, "_vld_drop"}, {31'h0, instr_valid}, 32'd0);
      chk({tag, "_req_next"}, {31'h0, imem_req}, 32'd1);
   endtask

   task automatic mem_ret(input logic [31:0] data, input bit keep, input logic [31:0] addr);
      exp_t e;
      imem_ack   = 1'b1;
      imem_rdata = data;
      if (keep) begin
         e.instr = data;
         e.pc    = addr;
         sb.push_back(e);
      end
      tick();
      imem_ack = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      br_taken = 1'b0; br_target = 32'h0;
      rst2_n = 1'b1; imem_ack2 = 1'b0; imem_rdata2 = 32'h0; instr_ready2 = 1'b0;
      br_taken2 = 1'b0; br_target2 = 32'h0;
      #2;
      rst_n = 1'b0; rst2_n = 1'b0;
      tick(); tick();

      // Reset state
      chk("rst_req", {31'h0, imem_req}, 32'd0);
      chk("rst_vld", {31'h0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_op", {26'h0, op}, 32'h0);
      chk("rst_pcout", pc_out, 32'h0);
      chk("rst_pc4", pc_plus4, 32'd4);
      chk("rst_addr", imem_addr, 32'h0);

      // Zero-wait fetch of lw at address 0
      rst_n = 1'b1;
      tick();
      chk("first_req", {31'h0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);
      mem_ret(32'h8C22_0004, 1'b1, 32'h0);
      chk("lw_op", {26'h0, op}, 32'h23);
      accept("lw");
      chk("addr4", imem_addr, 32'd4);

      // Ack delayed three cycles: request held stable
      for (int i = 0; i < 3; i++) begin
         chk("wait_req", {31'h0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, 32'd4);
         chk("wait_vld", {31'h0, instr_valid}, 32'd0);
         tick();
      end
      chk("wait_req4", {31'h0, imem_req}, 32'd1);
      chk("wait_addr4", imem_addr, 32'd4);
      mem_ret(32'h1085_0003, 1'b1, 32'd4);

      // Backpressure for five cycles on a beq
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld", {31'h0, instr_valid}, 32'd1);
         chk("bp_op", {26'h0, op}, 32'h04);
         chk("bp_instr", instr, 32'h1085_0003);
         chk("bp_pc", pc_out, 32'd4);
         chk("bp_req", {31'h0, imem_req}, 32'd0);
         tick();
      end
      accept("beq");
      chk("addr8", imem_addr, 32'd8);

      // Redirect in S_VALID squashes the held word
      mem_ret(32'h0085_1020, 1'b0, 32'd8);
      chk("sq_vld", {31'h0, instr_valid}, 32'd1);
      chk("sq_req", {31'h0, imem_req}, 32'd0);
      br_taken = 1'b1; br_target = 32'h0000_0043;
      tick();
      br_taken = 1'b0;
      chk("sq_vld0", {31'h0, instr_valid}, 32'd0);
      chk("sq_req1", {31'h0, imem_req}, 32'd1);
      chk("sq_addr", imem_addr, 32'h40);
      tick();
      chk("sq_still0", {31'h0, instr_valid}, 32'd0);

      // Redirect during a wait: request kept, returned word dropped
      br_taken = 1'b1; br_target = 32'h100;
      tick();
      br_taken = 1'b0;
      chk("pend_req", {31'h0, imem_req}, 32'd1);
      chk("pend_addr", imem_addr, 32'h40);
      mem_ret(32'hDEAD_BEEF, 1'b0, 32'h40);
      chk("pend_vld", {31'h0, instr_valid}, 32'd0);
      chk("pend_tgt", imem_addr, 32'h100);
      mem_ret(32'h8C44_0008, 1'b1, 32'h100);
      accept("tgt");
      chk("addr104", imem_addr, 32'h104);

      // Redirect coincident with ack
      br_taken = 1'b1; br_target = 32'h200;
      mem_ret(32'hBAD0_0001, 1'b0, 32'h104);
      br_taken = 1'b0;
      chk("coack_vld", {31'h0, instr_valid}, 32'd0);
      chk("coack_addr", imem_addr, 32'h200);
      chk("coack_req", {31'h0, imem_req}, 32'd1);

      // Redirect coincident with the decode handshake: redirect wins
      mem_ret(32'h0123_4567, 1'b0, 32'h200);
      chk("cohs_vld", {31'h0, instr_valid}, 32'd1);
      instr_ready = 1'b1; br_taken = 1'b1; br_target = 32'h300;
      tick();
      instr_ready = 1'b0; br_taken = 1'b0;
      chk("cohs_vld0", {31'h0, instr_valid}, 32'd0);
      chk("cohs_addr", imem_addr, 32'h300);

      // Second pending redirect overwrites the first
      br_taken = 1'b1; br_target = 32'h400;
      tick();
      br_target = 32'h500;
      tick();
      br_taken = 1'b0;
      mem_ret(32'hBAD0_0002, 1'b0, 32'h300);
      chk("ovr_addr", imem_addr, 32'h500);
      chk("ovr_vld", {31'h0, instr_valid}, 32'd0);
      mem_ret(32'hAC65_0010, 1'b1, 32'h500);
      accept("sw");
      chk("addr504", imem_addr, 32'h504);

      // Asynchronous reset mid-wait; late ack during reset ignored
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_req", {31'h0, imem_req}, 32'd0);
      chk("arst_vld", {31'h0, instr_valid}, 32'd0);
      chk("arst_addr", imem_addr, 32'h0);
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0003;
      tick();
      chk("arst_ack_req", {31'h0, imem_req}, 32'd0);
      chk("arst_ack_vld", {31'h0, instr_valid}, 32'd0);
      imem_ack = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("rest_req", {31'h0, imem_req}, 32'd1);
      chk("rest_addr", imem_addr, 32'h0);
      mem_ret(32'h8C22_0004, 1'b1, 32'h0);
      accept("rest");

      // RESET_PC at top of memory: pc+4 wraps to 0
      rst2_n = 1'b1;
      tick();
      chk("w_addr", imem_addr2, 32'hFFFF_FFFC);
      chk("w_req", {31'h0, imem_req2}, 32'd1);
      imem_ack2 = 1'b1; imem_rdata2 = 32'h2401_0001;
      tick();
      imem_ack2 = 1'b0;
      chk("w_vld", {31'h0, instr_valid2}, 32'd1);
      chk("w_instr", instr2, 32'h2401_0001);
      chk("w_op", {26'h0, op2}, 32'h09);
      chk("w_pcout", pc_out2, 32'hFFFF_FFFC);
      chk("w_pc4", pc_plus42, 32'h0);
      instr_ready2 = 1'b1;
      tick();
      instr_ready2 = 1'b0;
      chk("w_next", imem_addr2, 32'h0);
      chk("w_nreq", {31'h0, imem_req2}, 32'd1);
      tick();
      rst2_n = 1'b0;
      #1;
      chk("w_arst_req", {31'h0, imem_req2}, 32'd0);
      chk("w_arst_vld", {31'h0, instr_valid2}, 32'd0);
      tick();
      rst2_n = 1'b1;
      tick();
      chk("w_restart", imem_addr2, 32'hFFFF_FFFC);
      chk("w_restart_req", {31'h0, imem_req2}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
